vermicom_txfifo: RTL and testbench

//   Buffered UART transmitter peripheral on the CPU data bus, alongside the existing UART at device address 8'h82.
//   - CPU stores bytes into a FIFO without polling per character.
//   - An 8N1 serialiser drains the FIFO onto the tx line.
//   - An interrupt is raised when the FIFO has drained, if enabled.
//

---
 rtl/vermicom_txfifo.sv | 262 ++++++++++++++++++++++++++
 tb/tb_vermicom_txfifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vermicom_txfifo.sv
// vermicom_txfifo: buffered 8N1 UART transmitter on the CPU data bus.
// The CPU pushes bytes into a circular FIFO; a serialiser drains it onto tx.
// A level interrupt is raised when the FIFO is empty and the line is idle.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high
//   valid    bus request (pre-decoded); held by the master until ready
//   address  byte address, only [3:2] selects a register
//   wstrobe  byte write enables, all-zero means read
//   wdata    write data
//   rdata    read data, zero whenever ready is low
//   ready    one-cycle completion pulse, registered
//   irq      level interrupt: irq_en && FIFO empty && serialiser idle
//   tx       serial line, idle high
//
// Registers (address[3:2])
//   0 DATA     W: push wdata[7:0] when wstrobe[0]. R: 0
//   1 STATUS   R: [0] empty [1] full [2] busy [3] overflow [15:8] count
//              W: wstrobe[0] && wdata[3] clears overflow
//   2 CONTROL  [0] irq_en
//   3 DIVISOR  [15:0] clk cycles per bit, clamped to >= 2

module vermicom_txfifo #(
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned DEFAULT_DIVISOR = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] address,
    input  logic [3:0]  wstrobe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        irq,
    output logic        tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = 16;

    localparam logic [1:0] SEL_DATA    = 2'd0;
    localparam logic [1:0] SEL_STATUS  = 2'd1;
    localparam logic [1:0] SEL_CONTROL = 2'd2;
    localparam logic [1:0] SEL_DIVISOR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Control registers
    logic [DIV_W-1:0] divisor;
    logic             irq_en;
    logic             overflow;

    // Serialiser state
    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] bit_cnt;
    logic [DIV_W-1:0] bit_cnt_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic             tx_next;

    // Combinational helpers
    logic             do_req_c;
    logic [1:0]       sel_c;
    logic             wr_c;
    logic             push_c;
    logic             push_ok_c;
    logic             pop_c;
    logic             empty_c;
    logic             full_c;
    logic             busy_c;
    logic             bit_done_c;
    logic [31:0]      read_data_c;
    logic [DIV_W-1:0] div_merge_c;
    logic             unused_c;

    // A request is serviced only when ready is low, so each one costs two cycles
    assign do_req_c  = valid & ~ready;
    assign sel_c     = address[3:2];
    assign wr_c      = do_req_c & (|wstrobe);
    assign push_c    = wr_c & (sel_c == SEL_DATA) & wstrobe[0];
    assign empty_c   = (count == CNT_W'(0));
    assign full_c    = (count == CNT_W'(FIFO_DEPTH));
    assign push_ok_c = push_c & ~full_c;
    assign busy_c    = (state != ST_IDLE);
    assign bit_done_c = (bit_cnt == DIV_W'(0));

    assign unused_c = ^{address[31:4], address[1:0], wdata[31:16]};

    // Byte-lane merge of a DIVISOR write before clamping
    assign div_merge_c = {wstrobe[1] ? wdata[15:8] : divisor[15:8],
                          wstrobe[0] ? wdata[7:0]  : divisor[7:0]};

    // Register read mux
    always_comb begin
        read_data_c = 32'h0;
        case (sel_c)
            SEL_DATA:    read_data_c = 32'h0;
            SEL_STATUS:  read_data_c = {16'h0, 8'(count), 4'h0,
                                        overflow, busy_c, full_c, empty_c};
            SEL_CONTROL: read_data_c = {31'h0, irq_en};
            SEL_DIVISOR: read_data_c = {16'h0, divisor};
            default:     read_data_c = 32'h0;
        endcase
    end

    // Bus response and interrupt registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= 32'h0;
            irq   <= 1'b0;
        end else begin
            ready <= do_req_c;
            rdata <= do_req_c ? read_data_c : 32'h0;
            irq   <= irq_en & empty_c & ~busy_c;
        end
    end

    // Control registers and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            divisor  <= DIV_W'(DEFAULT_DIVISOR);
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_c && full_c) begin
                overflow <= 1'b1;
            end else if (wr_c && sel_c == SEL_STATUS && wstrobe[0] && wdata[3]) begin
                overflow <= 1'b0;
            end
            if (wr_c && sel_c == SEL_CONTROL && wstrobe[0]) begin
                irq_en <= wdata[0];
            end
            if (wr_c && sel_c == SEL_DIVISOR) begin
                divisor <= (div_merge_c < DIV_W'(2)) ? DIV_W'(2) : div_merge_c;
            end
        end
    end

    // FIFO storage; contents need no reset, pointers and count do
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    // Full is judged before this cycle's pop, so a push while full always drops
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= PTR_W'(0);
            rd_ptr <= PTR_W'(0);
            count  <= CNT_W'(0);
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Serialiser state register; tx is registered from the next-state value
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= DIV_W'(0);
            shift   <= 8'h0;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            tx      <= tx_next;
        end
    end

    // Serialiser next state: each bit lasts `divisor` cycles via a reloaded down-counter
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        tx_next      = 1'b1;
        pop_c        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!empty_c) begin
                    pop_c        = 1'b1;
                    shift_next   = mem[rd_ptr];
                    bit_cnt_next = divisor - DIV_W'(1);
                    state_next   = ST_START;
                    tx_next      = 1'b0;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_done_c) begin
                    state_next   = ST_DATA;
                    bit_idx_next = 3'd0;
                    bit_cnt_next = divisor - DIV_W'(1);
                    tx_next      = shift[0];
                end else begin
                    bit_cnt_next = bit_cnt - DIV_W'(1);
                end
            end
            ST_DATA: begin
                tx_next = shift[0];
                if (bit_done_c) begin
                    bit_cnt_next = divisor - DIV_W'(1);
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift[1];
                    end
                end else begin
                    bit_cnt_next = bit_cnt - DIV_W'(1);
                end
            end
            ST_STOP: begin
                tx_next = 1'b1;
                if (bit_done_c) begin
                    state_next = ST_IDLE;
                end else begin
                    bit_cnt_next = bit_cnt - DIV_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vermicom_txfifo.sv
// Testbench for vermicom_txfifo: directed scenarios followed by random bus traffic.
// A queue-based reference model predicts register reads, the tx waveform and irq.

module tb_vermicom_txfifo;

    localparam int DEPTH   = 16;
    localparam int DEF_DIV = 868;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;
    logic        tx;

    always #5 clk = ~clk;

    vermicom_txfifo #(
        .FIFO_DEPTH      (DEPTH),
        .DEFAULT_DIVISOR (DEF_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .address (address),
        .wstrobe (wstrobe),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .irq     (irq),
        .tx      (tx)
    );

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit          chk;
        logic [31:0] exp_v;
        logic [1:0]  sel;
    } rsp_t;
    rsp_t rd_q[$];

    // Reference model state: pending bytes, frame timer, register copies
    logic [7:0]  mq[$];
    int          busy_left;
    int          fdiv;
    logic [15:0] mdiv;
    logic [7:0]  cur;
    bit          m_ovf;
    bit          m_en;
    bit          m_rdy;
    bit          exp_irq;
    bit          exp_tx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Model: a frame occupies 10*divisor cycles, then at least one idle cycle
    always @(posedge clk) begin : model
        int          pre_size;
        bit          pre_idle;
        bit          svc;
        int          pos;
        logic [31:0] rv;
        logic [15:0] nv;
        if (reset) begin
            mq.delete();
            busy_left = 0;
            mdiv      = 16'(DEF_DIV);
            fdiv      = DEF_DIV;
            m_ovf     = 1'b0;
            m_en      = 1'b0;
            m_rdy     = 1'b0;
            exp_irq   = 1'b0;
            exp_tx    = 1'b1;
        end else begin
            pre_size = mq.size();
            pre_idle = (busy_left == 0);
            svc      = valid && !m_rdy;
            if (svc) begin
                case (address[3:2])
                    2'd0:    rv = 32'h0;
                    2'd1:    rv = {16'h0, 8'(pre_size), 4'h0, m_ovf, !pre_idle,
                                   pre_size == DEPTH, pre_size == 0};
                    2'd2:    rv = {31'h0, m_en};
                    default: rv = {16'h0, mdiv};
                endcase
                rd_q.push_back('{chk: (wstrobe == 4'h0), exp_v: rv, sel: address[3:2]});
            end
            exp_irq = m_en && (pre_size == 0) && pre_idle;
            if (!pre_idle) begin
                busy_left--;
            end else if (pre_size != 0) begin
                cur       = mq.pop_front();
                fdiv      = int'(mdiv);
                busy_left = 10 * fdiv;
            end
            if (svc && wstrobe != 4'h0) begin
                case (address[3:2])
                    2'd0: if (wstrobe[0]) begin
                        if (pre_size == DEPTH) m_ovf = 1'b1;
                        else mq.push_back(wdata[7:0]);
                    end
                    2'd1: if (wstrobe[0] && wdata[3]) m_ovf = 1'b0;
                    2'd2: if (wstrobe[0]) m_en = wdata[0];
                    default: begin
                        nv = {wstrobe[1] ? wdata[15:8] : mdiv[15:8],
                              wstrobe[0] ? wdata[7:0]  : mdiv[7:0]};
                        mdiv = (nv < 16'd2) ? 16'd2 : nv;
                    end
                endcase
            end
            m_rdy = svc;
            if (busy_left == 0) begin
                exp_tx = 1'b1;
            end else begin
                pos = (10 * fdiv - busy_left) / fdiv;
                if (pos == 0)      exp_tx = 1'b0;
                else if (pos == 9) exp_tx = 1'b1;
                else               exp_tx = cur[pos-1];
            end
        end
    end

    // Monitor: per-cycle line/irq/handshake checks and the read scoreboard
    always @(negedge clk) begin
        rsp_t r;
        if (mon_en) begin
            check("tx", 32'(tx), 32'(exp_tx));
            check("irq", 32'(irq), 32'(exp_irq));
            check("ready", 32'(ready), 32'(m_rdy));
            if (ready === 1'b1) begin
                if (rd_q.size() == 0) begin
                    check("sb_pending", 32'(rd_q.size()), 32'd1);
                end else begin
                    r = rd_q.pop_front();
                    if (r.chk) check($sformatf("rdata_reg%0d", r.sel), rdata, r.exp_v);
                end
            end else begin
                check("rdata_idle", rdata, 32'h0);
            end
        end
    end

    // All tasks start and end just after a falling edge
    task automatic bus(input logic [1:0] sel, input logic [3:0] ws, input logic [31:0] d);
        int n;
        bit was_high;
        was_high = valid;
        address  = {28'h0, sel, 2'b00};
        wstrobe  = ws;
        wdata    = d;
        valid    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 10);
        check("latency", 32'(n), was_high ? 32'd2 : 32'd1);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        valid = 1'b0;
        n = 0;
        while ((mq.size() != 0 || busy_left != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("drain_timeout", 32'(n), 32'd0);
        idle(3);
    endtask

    initial begin
        int r;
        reset   = 1'b1;
        valid   = 1'b0;
        address = 32'h0;
        wstrobe = 4'h0;
        wdata   = 32'h0;
        @(negedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;
        idle(2);

        // Reset state, then divisor 4
        bus(2'd1, 4'h0, 32'h0);
        bus(2'd3, 4'h3, 32'd4);
        idle(1);
        bus(2'd3, 4'h0, 32'h0);
        idle(1);

        // Single frame 0xA5, polling STATUS meanwhile
        bus(2'd0, 4'h1, 32'hA5);
        repeat (8) begin
            idle(1 + $urandom_range(0, 3));
            bus(2'd1, 4'h0, 32'h0);
        end
        wait_drain();

        // Overflow: 18 back-to-back pushes
        idle(1);
        for (int i = 0; i < 18; i++) bus(2'd0, 4'h1, 32'($urandom_range(0, 255)));
        bus(2'd1, 4'h0, 32'h0);
        bus(2'd1, 4'h1, 32'h8);
        bus(2'd1, 4'h0, 32'h0);
        wait_drain();

        // Interrupt enable, then a frame while enabled
        bus(2'd2, 4'h1, 32'h1);
        idle(4);
        bus(2'd0, 4'h1, 32'h55);
        wait_drain();
        bus(2'd2, 4'h0, 32'h0);
        idle(1);

        // Reset during the second data bit of the first frame
        bus(2'd0, 4'h1, 32'h3C);
        bus(2'd0, 4'h1, 32'hC3);
        bus(2'd0, 4'h1, 32'h99);
        idle(6);
        do_reset();
        idle(1);
        bus(2'd1, 4'h0, 32'h0);
        bus(2'd2, 4'h0, 32'h0);
        bus(2'd3, 4'h0, 32'h0);

        // Divisor clamp
        idle(1);
        bus(2'd3, 4'h3, 32'h0);
        bus(2'd3, 4'h0, 32'h0);
        bus(2'd0, 4'h1, 32'($urandom_range(0, 255)));
        wait_drain();

        // Random traffic
        repeat (250) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                bus(2'd0, 4'($urandom_range(1, 15)), $urandom);
            end else if (r <= 5) begin
                bus(2'd1, 4'h0, 32'h0);
            end else if (r == 6) begin
                bus(2'd1, 4'($urandom_range(1, 15)), $urandom);
            end else if (r == 7) begin
                bus(2'd2, 4'($urandom_range(1, 15)), $urandom);
            end else if (r == 8 && mq.size() == 0 && busy_left == 0) begin
                bus(2'd3, 4'($urandom_range(1, 3)), 32'($urandom_range(0, 6)));
            end else begin
                bus(2'($urandom_range(0, 3)), 4'h0, 32'h0);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        wait_drain();
        idle(3);
        check("sb_empty", 32'(rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
